// File: rtl/bids22_ledger_pkg.sv
// Shared types, constants and saturating helpers for the bids22 round ledger.
package bids22_ledger_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        X    = 2'b01,
        Y    = 2'b10,
        Z    = 2'b11
    } winner_e;

    typedef enum logic {
        ARMED = 1'b0,
        HELD  = 1'b1
    } ledger_state_e;

    // Queue entries carry the widest supported amount; the top narrows to AMT_W.
    localparam int AMT_MAX_W = 32;

    typedef struct packed {
        winner_e                winner;
        logic [AMT_MAX_W-1:0]   amt;
        logic [7:0]             round;
    } ledger_entry_t;

    localparam logic [2:0] DUP_ERR = 3'b101;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/bids22_result_fifo.sv
// First-word-fall-through queue of ledger entries; head is zero while empty.
module bids22_result_fifo
    import bids22_ledger_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  ledger_entry_t wr_data,
    output ledger_entry_t rd_data,
    output logic          full,
    output logic          empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ledger_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic [PTR_W:0]     count_d;
    logic               push_s;
    logic               pop_s;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == {(PTR_W+1){1'b0}});
    // A full queue still accepts a push when the same cycle pops the head.
    assign pop_s   = pop && !empty;
    assign push_s  = push && (!full || pop_s);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bids22_round_ledger.sv
// Round-result ledger: edge-detect FSM, winner encoding, saturating statistics.
// Optional BIDS22_LEDGER_CLEAR_EN adds a clr_stats input that zeroes the statistics.
module bids22_round_ledger
    import bids22_ledger_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AMT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef BIDS22_LEDGER_CLEAR_EN
    input  logic             clr_stats,
`endif
    input  logic             roundOver,
    input  logic             X_win,
    input  logic             Y_win,
    input  logic             Z_win,
    input  logic [AMT_W-1:0] maxBid,
    input  logic [2:0]       err,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [1:0]       rd_winner,
    output logic [AMT_W-1:0] rd_amt,
    output logic [7:0]       rd_round,
    output logic [7:0]       X_wins,
    output logic [7:0]       Y_wins,
    output logic [7:0]       Z_wins,
    output logic [31:0]      revenue,
    output logic [7:0]       round_cnt,
    output logic [7:0]       dup_cnt,
    output logic             fifo_full,
    output logic             overflow
);

    ledger_state_e  state_q, state_d;
    logic           capture_s;
    logic           clr_s;
    winner_e        winner_s;
    logic [AMT_W-1:0] amt_s;
    ledger_entry_t  wr_entry_s, head_s;
    logic           empty_s;
    logic [7:0]     x_wins_q, y_wins_q, z_wins_q, dup_cnt_q, round_cnt_q;
    logic [7:0]     x_wins_d, y_wins_d, z_wins_d, dup_cnt_d, round_cnt_d;
    logic [31:0]    revenue_q, revenue_d;
    logic           overflow_q, overflow_d;

`ifdef BIDS22_LEDGER_CLEAR_EN
    assign clr_s = clr_stats;
`else
    assign clr_s = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ARMED;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED:   state_d = roundOver ? HELD : ARMED;
            HELD:    state_d = roundOver ? HELD : ARMED;
            default: state_d = ARMED;
        endcase
    end

    always_comb begin
        capture_s = 1'b0;
        case (state_q)
            ARMED:   capture_s = roundOver;
            HELD:    capture_s = 1'b0;
            default: capture_s = 1'b0;
        endcase
    end

    // Ties and no-winner rounds both record NONE with a zero amount.
    always_comb begin
        winner_s = NONE;
        amt_s    = {AMT_W{1'b0}};
        case ({X_win, Y_win, Z_win})
            3'b100:  begin winner_s = X; amt_s = maxBid; end
            3'b010:  begin winner_s = Y; amt_s = maxBid; end
            3'b001:  begin winner_s = Z; amt_s = maxBid; end
            default: begin winner_s = NONE; amt_s = {AMT_W{1'b0}}; end
        endcase
    end

    assign wr_entry_s = '{winner: winner_s, amt: AMT_MAX_W'(amt_s), round: round_cnt_q};

    bids22_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture_s),
        .pop     (rd_en),
        .wr_data (wr_entry_s),
        .rd_data (head_s),
        .full    (fifo_full),
        .empty   (empty_s)
    );

    generate
        if (AMT_W < AMT_MAX_W) begin : g_amt_unused
            logic unused_amt_s;
            assign unused_amt_s = ^head_s.amt[AMT_MAX_W-1:AMT_W];
        end
    endgenerate

    assign rd_valid  = !empty_s;
    assign rd_winner = head_s.winner;
    assign rd_amt    = head_s.amt[AMT_W-1:0];
    assign rd_round  = head_s.round;

    // A clear coinciding with a capture lets the capture build on the zeroed value.
    always_comb begin
        x_wins_d    = clr_s ? 8'd0  : x_wins_q;
        y_wins_d    = clr_s ? 8'd0  : y_wins_q;
        z_wins_d    = clr_s ? 8'd0  : z_wins_q;
        dup_cnt_d   = clr_s ? 8'd0  : dup_cnt_q;
        revenue_d   = clr_s ? 32'd0 : revenue_q;
        overflow_d  = clr_s ? 1'b0  : overflow_q;
        round_cnt_d = round_cnt_q;
        if (capture_s) begin
            if (winner_s == X) x_wins_d = sat_inc8(x_wins_d);
            else               x_wins_d = x_wins_d;
            if (winner_s == Y) y_wins_d = sat_inc8(y_wins_d);
            else               y_wins_d = y_wins_d;
            if (winner_s == Z) z_wins_d = sat_inc8(z_wins_d);
            else               z_wins_d = z_wins_d;
            if (err == DUP_ERR) dup_cnt_d = sat_inc8(dup_cnt_d);
            else                dup_cnt_d = dup_cnt_d;
            revenue_d   = sat_add32(revenue_d, 32'(amt_s));
            overflow_d  = overflow_d | (fifo_full && !rd_en);
            round_cnt_d = round_cnt_q + 8'd1;
        end else begin
            round_cnt_d = round_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_wins_q    <= 8'd0;
            y_wins_q    <= 8'd0;
            z_wins_q    <= 8'd0;
            dup_cnt_q   <= 8'd0;
            round_cnt_q <= 8'd0;
            revenue_q   <= 32'd0;
            overflow_q  <= 1'b0;
        end else begin
            x_wins_q    <= x_wins_d;
            y_wins_q    <= y_wins_d;
            z_wins_q    <= z_wins_d;
            dup_cnt_q   <= dup_cnt_d;
            round_cnt_q <= round_cnt_d;
            revenue_q   <= revenue_d;
            overflow_q  <= overflow_d;
        end
    end

    assign X_wins    = x_wins_q;
    assign Y_wins    = y_wins_q;
    assign Z_wins    = z_wins_q;
    assign dup_cnt   = dup_cnt_q;
    assign round_cnt = round_cnt_q;
    assign revenue   = revenue_q;
    assign overflow  = overflow_q;

endmodule
